// File: rtl/collector_pkg.sv
// collector_pkg: shared types and sizing helpers for layer_output_collector.
//   ELEM_WIDTH : default element width used by elem_t
//   NUM_BANKS  : ping-pong bank count
//   idx_width  : element-index width for a vector of n elements
package collector_pkg;
  localparam int ELEM_WIDTH = 32;
  localparam int NUM_BANKS = 2;
  typedef logic signed [ELEM_WIDTH-1:0] elem_t;
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/collector_bank.sv
// collector_bank: one vector bank of the collector.
//   we/idx/data       : element write port
//   set_full/clr_full : full flag control (set wins)
//   full              : bank holds a complete vector
//   rd_data           : packed vector, element 0 in the low bits
module collector_bank
  import collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELEMS = 8,
  localparam int IW = idx_width(NUM_ELEMS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            we,
  input  logic [IW-1:0]                   idx,
  input  logic [DATA_WIDTH-1:0]           data,
  input  logic                            set_full,
  input  logic                            clr_full,
  output logic                            full,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0] rd_data
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      full <= 1'b0;
    end else begin
      if (we) rd_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= data;
      if (set_full) full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end
endmodule

// File: rtl/layer_output_collector.sv
// layer_output_collector: gathers a serial element stream into ping-pong vectors with valid/ready output.
//   valid_in/data_in          : element stream, no backpressure
//   out_data/out_valid/out_ready : vector handshake
//   overflow/clear_overflow   : sticky drop flag and its clear
//   fill_level                : elements in the current write bank
module layer_output_collector
  import collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELEMS = 8,
  localparam int FW = $clog2(NUM_ELEMS + 1),
  localparam int VW = NUM_ELEMS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [VW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [FW-1:0]         fill_level
);
  localparam int IW = idx_width(NUM_ELEMS);
  logic wr_bank, rd_bank, hs, accept, drop, last;
  logic [FW-1:0] wr_idx;
  logic [NUM_BANKS-1:0] full;
  logic [VW-1:0] rd_data [NUM_BANKS];
  assign out_valid = full[rd_bank];
  assign out_data = rd_data[rd_bank];
  assign hs = out_valid & out_ready;
  // A full write bank still accepts when the reader is releasing that same bank this cycle.
  assign accept = valid_in & (~full[wr_bank] | (hs & (rd_bank == wr_bank)));
  assign drop = valid_in & ~accept;
  assign last = wr_idx == FW'(NUM_ELEMS - 1);
  assign fill_level = wr_idx;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    collector_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_ELEMS(NUM_ELEMS)) u_bank (
      .clk(clk),
      .rst_n(rst_n),
      .we(accept & (wr_bank == 1'(b))),
      .idx(wr_idx[IW-1:0]),
      .data(data_in),
      .set_full(accept & last & (wr_bank == 1'(b))),
      .clr_full(hs & (rd_bank == 1'(b))),
      .full(full[b]),
      .rd_data(rd_data[b])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_idx <= last ? '0 : wr_idx + 1'b1;
        if (last) wr_bank <= ~wr_bank;
      end
      if (hs) rd_bank <= ~rd_bank;
      overflow <= drop | (overflow & ~clear_overflow);
    end
  end
endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector: self-checking bench for layer_output_collector using a queue-based reference model.
module tb_layer_output_collector;
  import collector_pkg::*;
  localparam int DW = 32;
  localparam int N = 8;
  localparam int FW = $clog2(N + 1);
  localparam int VW = N * DW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic out_ready = 1'b0;
  logic clear_overflow = 1'b0;
  logic [VW-1:0] out_data;
  logic out_valid, overflow;
  logic [FW-1:0] fill_level;
  int total = 0;
  int fails = 0;
  logic [VW-1:0] mq[$];
  logic [DW-1:0] part[$];
  logic m_ovf = 1'b0;

  layer_output_collector #(.DATA_WIDTH(DW), .NUM_ELEMS(N)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clear_overflow(clear_overflow), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic [DW-1:0] d;
    logic rdy;
    logic ev;
    logic [FW-1:0] ef;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] seq_vec(input int s);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(s + i);
    return v;
  endfunction

  // Two vector slots of capacity; a vector leaving frees a slot for this same cycle.
  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic [VW-1:0] nv;
    bit hs, acc;
    hs = (mq.size() > 0) && rdy;
    acc = v && ((mq.size() - int'(hs)) < 2);
    if (hs) void'(mq.pop_front());
    if (acc) begin
      part.push_back(d);
      if (part.size() == N) begin
        for (int i = 0; i < N; i++) nv[i*DW +: DW] = part[i];
        mq.push_back(nv);
        part.delete();
      end
    end
    if (v && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    valid_in = v;
    data_in = d;
    out_ready = rdy;
    clear_overflow = clr;
    @(posedge clk);
    model_step(v, d, rdy, clr);
    #1;
    chk("out_valid", VW'(out_valid), VW'(mq.size() > 0));
    chk("fill_level", VW'(fill_level), VW'(part.size()));
    chk("overflow", VW'(overflow), VW'(m_ovf));
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
    valid_in = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = 1'b0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    @(posedge clk);
    mq.delete();
    part.delete();
    m_ovf = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("rst_valid", VW'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_fill", VW'(fill_level), '0);
    chk("rst_ovf", VW'(overflow), '0);
  endtask

  initial begin
    logic [VW-1:0] sv;
    int vals[N];
    vals = '{-5, 0, 7, 1, 2, 3, 4, 5};
    for (int i = 0; i < N; i++) begin
      tbl[i].v = 1'b1;
      tbl[i].d = DW'(i + 1);
      tbl[i].rdy = 1'b1;
      tbl[i].ev = (i == N - 1);
      tbl[i].ef = (i == N - 1) ? '0 : FW'(i + 1);
    end
    tbl[N].v = 1'b0;
    tbl[N].d = '0;
    tbl[N].rdy = 1'b1;
    tbl[N].ev = 1'b0;
    tbl[N].ef = '0;

    do_reset();
    for (int i = 0; i <= N; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
      chk("tbl_valid", VW'(out_valid), VW'(tbl[i].ev));
      chk("tbl_fill", VW'(fill_level), VW'(tbl[i].ef));
      if (i == N - 1) chk("tbl_data", out_data, seq_vec(1));
    end

    do_reset();
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 8) chk("bp_first", out_data, seq_vec(1));
    end
    chk("bp_ovf", VW'(overflow), VW'(1));
    chk("bp_valid", VW'(out_valid), VW'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_second", out_data, seq_vec(9));
    chk("bp_second_valid", VW'(out_valid), VW'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", VW'(out_valid), '0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("bp_clear", VW'(overflow), '0);

    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, DW'(100), 1'b1, 1'b0);
    chk("ft_fill", VW'(fill_level), VW'(1));
    chk("ft_ovf", VW'(overflow), '0);
    chk("ft_next", out_data, seq_vec(9));
    for (int i = 101; i <= 107; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
    chk("ft_vec", out_data, seq_vec(100));

    do_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i + 40), 1'b0, 1'b0);
    do_reset();
    for (int i = 21; i <= 28; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    chk("rm_vec", out_data, seq_vec(21));

    do_reset();
    for (int i = 0; i < N; i++) begin
      sv[i*DW +: DW] = DW'(vals[i]);
      cycle(1'b1, DW'(vals[i]), 1'b0, 1'b0);
    end
    chk("sign_e0", VW'(out_data[DW-1:0]), VW'(32'hFFFF_FFFB));
    chk("sign_signed", VW'(elem_t'(out_data[DW-1:0]) < 0), VW'(1));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("hold_data", out_data, sv);
    end
    for (int i = 0; i < N; i++) cycle(1'b1, DW'(i + 60), 1'b0, 1'b0);
    cycle(1'b1, DW'(9), 1'b0, 1'b1);
    chk("clr_vs_drop", VW'(overflow), VW'(1));

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom),
            1'($urandom_range(0, 99) < ((k < 1500) ? 30 : 80)),
            1'($urandom_range(0, 15) == 0));
      if (k == 2000) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
